// File: rtl/decoder_n_stream_if.sv
// Stream bundle for decoder_n_stream: code input side,
// decoded output side and the completed-decode counter.
interface decoder_n_stream_if #(
   parameter int SEL_WIDTH   = 3,
   parameter int NUM_OUTPUTS = 8,
   parameter int COUNT_WIDTH = 8
);
   logic                   Enable_In;
   logic                   Mode_In;
   logic                   In_Valid_In;
   logic                   In_Ready_Out;
   logic [SEL_WIDTH-1:0]   Encoded_Value_In;
   logic                   Out_Valid_Out;
   logic                   Out_Ready_In;
   logic [NUM_OUTPUTS-1:0] Decoded_Out;
   logic                   Range_Error_Out;
   logic [COUNT_WIDTH-1:0] Decode_Count_Out;

   modport slave (
      input  Enable_In, Mode_In, In_Valid_In,
      input  Encoded_Value_In, Out_Ready_In,
      output In_Ready_Out, Out_Valid_Out,
      output Decoded_Out, Range_Error_Out,
      output Decode_Count_Out
   );

   modport master (
      output Enable_In, Mode_In, In_Valid_In,
      output Encoded_Value_In, Out_Ready_In,
      input  In_Ready_Out, Out_Valid_Out,
      input  Decoded_Out, Range_Error_Out,
      input  Decode_Count_Out
   );
endinterface

// File: rtl/decoder_n_stream.sv
// Registered one-hot / thermometer decoder with a 2-entry
// output buffer and a saturating completed-decode counter.
module decoder_n_stream #(
   parameter int SEL_WIDTH   = 3,
   parameter int NUM_OUTPUTS = 8,
   parameter int COUNT_WIDTH = 8
) (
   input logic           Clock_In,
   input logic           Reset_n_In,
   decoder_n_stream_if.slave bus
);

   generate
      if (SEL_WIDTH < 1 || SEL_WIDTH > 8 ||
          NUM_OUTPUTS < 2 ||
          NUM_OUTPUTS > (1 << SEL_WIDTH) ||
          COUNT_WIDTH < 1) begin : g_bad_params
         $error("decoder_n_stream: illegal parameters");
      end
   endgenerate

   // slot 0 is the head; slot 1 is only valid when slot 0 is
   logic [1:0]             vld_q, vld_d;
   logic [1:0]             err_q, err_d;
   logic [NUM_OUTPUTS-1:0] dec_q [2];
   logic [NUM_OUTPUTS-1:0] dec_d [2];
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

   logic [NUM_OUTPUTS-1:0] new_dec;
   logic                   new_err;
   logic [31:0]            code_w;
   logic                   in_rdy;
   logic                   push;
   logic                   pop;

   assign in_rdy = Reset_n_In & bus.Enable_In & ~vld_q[1];
   assign push   = bus.In_Valid_In & in_rdy;
   assign pop    = vld_q[0] & bus.Out_Ready_In;

   // decode the incoming code in the mode sampled with it
   always_comb begin
      new_dec = '0;
      new_err = 1'b0;
      code_w  = 32'(bus.Encoded_Value_In);
      if (code_w >= 32'(NUM_OUTPUTS)) begin
         new_err = 1'b1;
      end else begin
         for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (bus.Mode_In)
               new_dec[i] = (unsigned'(i) <= code_w);
            else
               new_dec[i] = (unsigned'(i) == code_w);
         end
      end
   end

   // shift out on pop, then append on push into first free slot
   always_comb begin
      vld_d = vld_q;
      err_d = err_q;
      dec_d = dec_q;
      cnt_d = cnt_q;
      if (pop) begin
         vld_d    = {1'b0, vld_q[1]};
         dec_d[0] = dec_q[1];
         err_d[0] = err_q[1];
         dec_d[1] = '0;
         err_d[1] = 1'b0;
         if (cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
      end
      if (push) begin
         if (!vld_d[0]) begin
            vld_d[0] = 1'b1;
            dec_d[0] = new_dec;
            err_d[0] = new_err;
         end else begin
            vld_d[1] = 1'b1;
            dec_d[1] = new_dec;
            err_d[1] = new_err;
         end
      end
   end

   // buffer and counter state
   always_ff @(posedge Clock_In or negedge Reset_n_In) begin
      if (!Reset_n_In) begin
         vld_q    <= '0;
         err_q    <= '0;
         dec_q[0] <= '0;
         dec_q[1] <= '0;
         cnt_q    <= '0;
      end else begin
         vld_q    <= vld_d;
         err_q    <= err_d;
         dec_q[0] <= dec_d[0];
         dec_q[1] <= dec_d[1];
         cnt_q    <= cnt_d;
      end
   end

   assign bus.In_Ready_Out     = in_rdy;
   assign bus.Out_Valid_Out    = vld_q[0];
   assign bus.Decoded_Out      = vld_q[0] ? dec_q[0] : '0;
   assign bus.Range_Error_Out  = vld_q[0] & err_q[0];
   assign bus.Decode_Count_Out = cnt_q;

endmodule

// File: tb/tb_decoder_n_stream.sv
// Bench for decoder_n_stream: an 8-output/8-bit-count build and a
// 6-output/2-bit-count build share one stimulus stream.
module tb_decoder_n_stream;

   typedef struct {
      logic [2:0] code;
      logic       mode;
      logic [7:0] da;
      logic       ea;
      logic [7:0] db;
      logic       eb;
   } vec_t;

   typedef struct {
      logic [7:0] d;
      logic       e;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en, mode, in_valid, out_ready;
   logic [2:0] code;
   ent_t       exp_a, exp_b;

   ent_t qa[$];
   ent_t qb[$];
   int   ca, cb;
   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t vecs [13];
   bit   ok;

   always #5 clk = ~clk;

   decoder_n_stream_if #(3, 8, 8) ifa ();
   decoder_n_stream_if #(3, 6, 2) ifb ();

   assign ifa.Enable_In        = en;
   assign ifa.Mode_In          = mode;
   assign ifa.In_Valid_In      = in_valid;
   assign ifa.Encoded_Value_In = code;
   assign ifa.Out_Ready_In     = out_ready;
   assign ifb.Enable_In        = en;
   assign ifb.Mode_In          = mode;
   assign ifb.In_Valid_In      = in_valid;
   assign ifb.Encoded_Value_In = code;
   assign ifb.Out_Ready_In     = out_ready;

   decoder_n_stream #(
      .SEL_WIDTH(3), .NUM_OUTPUTS(8), .COUNT_WIDTH(8)
   ) dut_a (
      .Clock_In(clk), .Reset_n_In(rst_n), .bus(ifa)
   );

   decoder_n_stream #(
      .SEL_WIDTH(3), .NUM_OUTPUTS(6), .COUNT_WIDTH(2)
   ) dut_b (
      .Clock_In(clk), .Reset_n_In(rst_n), .bus(ifb)
   );

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h",
                  nm, act, req);
      end
   endtask

   function automatic ent_t model(input int v, input bit m,
                                  input int n);
      ent_t r;
      r.d = '0;
      r.e = 1'b0;
      if (v >= n) r.e = 1'b1;
      else if (m) r.d = 8'(((1 << (v + 1)) - 1));
      else r.d = 8'(1 << v);
      return r;
   endfunction

   task automatic set_exp(input vec_t v);
      code  = v.code;
      mode  = v.mode;
      exp_a = '{v.da, v.ea};
      exp_b = '{v.db, v.eb};
   endtask

   // offer one code until accepted or budget runs out
   task automatic send(input vec_t v, input int budget,
                       output bit acc);
      acc = 1'b0;
      set_exp(v);
      in_valid = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         acc = ifa.In_Ready_Out;
         @(posedge clk);
         #1;
         if (acc) break;
      end
      in_valid = 1'b0;
      if (!acc) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: code %0d not accepted",
                  v.code);
      end
   endtask

   // scoreboard: compare head, pop on handshake, push on accept
   always @(negedge clk) begin
      if (!rst_n) begin
         qa.delete();
         qb.delete();
         ca = 0;
         cb = 0;
         chk("rst_out_a", {ifa.Out_Valid_Out, ifa.Decoded_Out,
             ifa.Range_Error_Out, ifa.Decode_Count_Out}, 0);
         chk("rst_out_b", {ifb.Out_Valid_Out, ifb.Decoded_Out,
             ifb.Range_Error_Out, ifb.Decode_Count_Out}, 0);
      end else begin
         chk("rdy_a", ifa.In_Ready_Out, en && qa.size() < 2);
         chk("vld_a", ifa.Out_Valid_Out, qa.size() != 0);
         chk("cnt_a", ifa.Decode_Count_Out, ca);
         if (qa.size() != 0) begin
            chk("dec_a", ifa.Decoded_Out, qa[0].d);
            chk("err_a", ifa.Range_Error_Out, qa[0].e);
            if (out_ready) begin
               void'(qa.pop_front());
               if (ca < 255) ca++;
            end
         end else begin
            chk("blank_a", {ifa.Decoded_Out,
                ifa.Range_Error_Out}, 0);
         end
         if (in_valid && ifa.In_Ready_Out) qa.push_back(exp_a);

         chk("rdy_b", ifb.In_Ready_Out, en && qb.size() < 2);
         chk("vld_b", ifb.Out_Valid_Out, qb.size() != 0);
         chk("cnt_b", ifb.Decode_Count_Out, cb);
         if (qb.size() != 0) begin
            chk("dec_b", {2'b00, ifb.Decoded_Out}, qb[0].d);
            chk("err_b", ifb.Range_Error_Out, qb[0].e);
            if (out_ready) begin
               void'(qb.pop_front());
               if (cb < 3) cb++;
            end
         end else begin
            chk("blank_b", {ifb.Decoded_Out,
                ifb.Range_Error_Out}, 0);
         end
         if (in_valid && ifb.In_Ready_Out) qb.push_back(exp_b);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{3'd0, 1'b0, 8'h01, 1'b0, 8'h01, 1'b0};
      vecs[1]  = '{3'd1, 1'b0, 8'h02, 1'b0, 8'h02, 1'b0};
      vecs[2]  = '{3'd2, 1'b0, 8'h04, 1'b0, 8'h04, 1'b0};
      vecs[3]  = '{3'd3, 1'b0, 8'h08, 1'b0, 8'h08, 1'b0};
      vecs[4]  = '{3'd4, 1'b0, 8'h10, 1'b0, 8'h10, 1'b0};
      vecs[5]  = '{3'd5, 1'b0, 8'h20, 1'b0, 8'h20, 1'b0};
      vecs[6]  = '{3'd6, 1'b0, 8'h40, 1'b0, 8'h00, 1'b1};
      vecs[7]  = '{3'd7, 1'b0, 8'h80, 1'b0, 8'h00, 1'b1};
      vecs[8]  = '{3'd0, 1'b1, 8'h01, 1'b0, 8'h01, 1'b0};
      vecs[9]  = '{3'd3, 1'b1, 8'h0F, 1'b0, 8'h0F, 1'b0};
      vecs[10] = '{3'd7, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b1};
      vecs[11] = '{3'd5, 1'b0, 8'h20, 1'b0, 8'h20, 1'b0};
      vecs[12] = '{3'd5, 1'b1, 8'h3F, 1'b0, 8'h3F, 1'b0};

      rst_n     = 1'b0;
      en        = 1'b1;
      mode      = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      code      = '0;
      exp_a     = '{8'h00, 1'b0};
      exp_b     = '{8'h00, 1'b0};

      #12;
      chk("rst_rdy_a", ifa.In_Ready_Out, 0);
      chk("rst_rdy_b", ifb.In_Ready_Out, 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // back-to-back one-hot, thermometer, mode switch
      for (int i = 0; i < 13; i++) begin
         send(vecs[i], 4, ok);
         chk("lat_vld", ifa.Out_Valid_Out, 1);
         chk("lat_dec", ifa.Decoded_Out, vecs[i].da);
         if (i < 8) chk("tput_rdy", ifa.In_Ready_Out, 1);
         if (i >= 1 && i <= 5)
            chk("sat_cnt_b", ifb.Decode_Count_Out,
                (i < 3) ? i : 3);
         if (i == 8) chk("cnt8", ifa.Decode_Count_Out, 8);
      end
      repeat (2) @(posedge clk);
      #1;

      // consumer stall with a third code waiting
      out_ready = 1'b0;
      send(vecs[2], 4, ok);
      send(vecs[4], 4, ok);
      chk("full_rdy", ifa.In_Ready_Out, 0);
      set_exp(vecs[6]);
      in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("stall_dec", ifa.Decoded_Out, 8'h04);
         chk("stall_rdy", ifa.In_Ready_Out, 0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      send(vecs[6], 5, ok);
      chk("third_dec", ifa.Decoded_Out, 8'h40);
      repeat (2) @(posedge clk);
      #1;

      // enable low while full: no push, entries drain
      out_ready = 1'b0;
      send(vecs[1], 4, ok);
      send(vecs[3], 4, ok);
      en = 1'b0;
      set_exp(vecs[7]);
      in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("en_rdy", ifa.In_Ready_Out, 0);
         chk("en_dec", ifa.Decoded_Out, 8'h02);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("drain_vld", ifa.Out_Valid_Out, 0);
      chk("drain_dec", ifa.Decoded_Out, 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      en       = 1'b1;

      // asynchronous reset with two entries held
      out_ready = 1'b0;
      send(vecs[2], 4, ok);
      send(vecs[4], 4, ok);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_a", {ifa.Out_Valid_Out, ifa.Decoded_Out,
          ifa.Range_Error_Out, ifa.Decode_Count_Out}, 0);
      chk("arst_b", {ifb.Out_Valid_Out, ifb.Decoded_Out,
          ifb.Range_Error_Out, ifb.Decode_Count_Out}, 0);
      chk("arst_rdy", ifa.In_Ready_Out, 0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;

      // range flag on the 6-output build
      for (int i = 5; i < 8; i++) begin
         send(vecs[i], 4, ok);
         chk("rng_dec_b", ifb.Decoded_Out, vecs[i].db[5:0]);
         chk("rng_err_b", ifb.Range_Error_Out, vecs[i].eb);
      end
      @(posedge clk);
      #1;
      chk("rng_cnt_b", ifb.Decode_Count_Out, 3);
      chk("rng_cnt_a", ifa.Decode_Count_Out, 3);

      // random traffic against the queue model
      for (int c = 0; c < 200; c++) begin
         en        = ($urandom_range(0, 7) != 0);
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         code      = 3'($urandom_range(0, 7));
         mode      = 1'($urandom_range(0, 1));
         exp_a     = model(int'(code), mode, 8);
         exp_b     = model(int'(code), mode, 6);
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      en        = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("lost_a", qa.size(), 0);
      chk("lost_b", qb.size(), 0);

      $display("[TB] %0d tests run, %0d failed",
               n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/decoder_n_stream.md
Name: decoder_n_stream

Overview:
- Parametrised, registered successor to the combinational 3:8 decoder.
- Decodes a SEL_WIDTH-bit code into NUM_OUTPUTS lines, selectable one-hot or thermometer.
- Valid/ready handshakes on both sides, with a 2-entry output buffer so a stalled consumer never drops codes.
- Sits between a code-producing control block and downstream select/enable logic; a saturating counter records completed decodes.

Parameters:
- SEL_WIDTH, 3: width of Encoded_Value_In. Legal range 1..8.
- NUM_OUTPUTS, 8: number of decoded lines. Legal range 2..2^SEL_WIDTH; an elaboration-time check rejects illegal values.
- COUNT_WIDTH, 8: width of Decode_Count_Out.

Ports:
- Clock_In  input  1  single clock; all state changes on the rising edge.
- Reset_n_In  input  1  asynchronous active-low reset.
- Enable_In  input  1  1 = accept new codes; 0 = input side stalled, output side keeps draining.
- Mode_In  input  1  0 = one-hot, 1 = thermometer; sampled per accepted code.
- In_Valid_In  input  1  producer has a code.
- In_Ready_Out  output  1  block can accept a code.
- Encoded_Value_In  input  SEL_WIDTH  code to decode.
- Out_Valid_Out  output  1  head entry valid.
- Out_Ready_In  input  1  consumer takes the head entry.
- Decoded_Out  output  NUM_OUTPUTS  decoded lines of the head entry.
- Range_Error_Out  output  1  head entry code was >= NUM_OUTPUTS.
- Decode_Count_Out  output  COUNT_WIDTH  saturating count of output handshakes.

Behaviour:
- Reset (Reset_n_In low, asynchronous, any time including mid-transfer):
  - Both buffer entries are invalidated and their contents cleared.
  - Out_Valid_Out = 0, Decoded_Out = 0, Range_Error_Out = 0, Decode_Count_Out = 0.
  - In_Ready_Out = 0 while reset is asserted.
  - Release takes effect at the first rising edge after deassertion.
- Occupancy and ready:
  - Occupancy is 0, 1 or 2.
  - In_Ready_Out = Enable_In AND (occupancy < 2). Combinational from Enable_In and registered occupancy; no dependency on Out_Ready_In.
- Push: In_Valid_In AND In_Ready_Out at a rising edge. Decode is computed from Encoded_Value_In and Mode_In at push time and stored with the entry, along with the range flag.
- Decode rules, for code v:
  - One-hot: bit i = (i == v).
  - Thermometer: bit i = (i <= v).
  - v >= NUM_OUTPUTS: all bits 0 and range flag = 1, in both modes.
  - v < NUM_OUTPUTS: range flag = 0.
- Pop: Out_Valid_Out AND Out_Ready_In at a rising edge. The head is removed and the second entry, if any, becomes head on the same edge.
- Latency: a code pushed into an empty buffer at edge k appears on Out_Valid_Out/Decoded_Out after edge k. Zero bubbles at full throughput: push and pop every cycle with occupancy 1.
- Simultaneous push and pop: occupancy unchanged. At occupancy 2, push is impossible since In_Ready_Out = 0.
- Output blanking: when Out_Valid_Out = 0, Decoded_Out = 0 and Range_Error_Out = 0. Outputs are never Z.
- Output stability: head outputs are held stable while Out_Valid_Out = 1 and Out_Ready_In = 0.
- Enable_In low:
  - No push.
  - Stored entries keep draining normally.
  - Mode_In changes never alter stored entries.
- Decode_Count_Out increments by 1 on every pop and saturates at 2^COUNT_WIDTH - 1. Out-of-range entries are counted.

Test Plan:
- Reset, then Enable_In = 1, Mode_In = 0, Out_Ready_In = 1; push codes 0..7 back-to-back.
  - Decoded_Out sequence is 0x01, 0x02, 0x04 … 0x80, one per cycle, each visible one edge after its push.
  - Decode_Count_Out = 8; In_Ready_Out stays 1 throughout.
- Mode_In = 1; push 0, 3, 7.
  - Decoded_Out is 0x01, 0x0F, 0xFF.
  - Then push 5 with Mode_In = 0 followed by 5 with Mode_In = 1: Decoded_Out is 0x20 then 0x3F.
- Out_Ready_In = 0; push 2, 4, 6.
  - Two codes accepted; In_Ready_Out drops to 0 after the second push.
  - Decoded_Out holds 0x04 while stalled.
  - Raise Out_Ready_In: outputs 0x04, 0x10, then the third code is accepted and 0x40 follows.
- Build NUM_OUTPUTS = 6, SEL_WIDTH = 3; push 5, 6, 7.
  - Decoded_Out is 0x20 with Range_Error_Out = 0.
  - Then 0x00 with Range_Error_Out = 1, twice.
  - Decode_Count_Out = 3.
- Buffer holding two entries with Out_Ready_In = 0, then drop Enable_In and drive In_Valid_In = 1.
  - In_Ready_Out = 0 and no push occurs.
  - Raise Out_Ready_In: both entries drain, then Out_Valid_Out = 0 and Decoded_Out = 0.
  - Assert Reset_n_In low mid-stall with two entries held: all outputs clear immediately, without waiting for a clock edge.
- COUNT_WIDTH = 2; perform 5 pops.
  - Decode_Count_Out goes 1, 2, 3, 3, 3.
- Random stimulus: 200 random valid/ready/mode/code patterns against a reference queue model.
  - Zero mismatches, no lost or duplicated codes.
